// File: rtl/vx_pe_dispatch.sv
// vx_pe_dispatch: PE router with per-PE credits and round-robin commit merge; define VX_PE_DISPATCH_ORDERED_EN for in-order commits
module vx_pe_dispatch #(
  parameter int PE_COUNT    = 2,
  parameter int NUM_LANES   = 4,
  parameter int MAX_PENDING = 4,
  parameter int ORDER_DEPTH = 8,
  parameter int PE_SEL_BITS = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1),
  parameter int DATA_W      = NUM_LANES * 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PE_SEL_BITS-1:0]           pe_sel,
  input  logic                             execute_in_valid,
  input  logic [DATA_W-1:0]                execute_in_data,
  output logic                             execute_in_ready,
  output logic [PE_COUNT-1:0]              execute_out_valid,
  output logic [PE_COUNT-1:0][DATA_W-1:0]  execute_out_data,
  input  logic [PE_COUNT-1:0]              execute_out_ready,
  input  logic [PE_COUNT-1:0]              commit_in_valid,
  input  logic [PE_COUNT-1:0][DATA_W-1:0]  commit_in_data,
  input  logic [PE_COUNT-1:0]              commit_in_eop,
  output logic [PE_COUNT-1:0]              commit_in_ready,
  output logic                             commit_out_valid,
  output logic [DATA_W-1:0]                commit_out_data,
  output logic                             commit_out_eop,
  input  logic                             commit_out_ready,
  output logic [PE_COUNT-1:0]              pe_busy,
  output logic                             idle
);
  localparam logic [PE_SEL_BITS:0] PE_LIM = (PE_SEL_BITS + 1)'(PE_COUNT);
  logic [CNT_W-1:0] pending [PE_COUNT];
  logic [PE_SEL_BITS-1:0] rr_ptr, win;
  logic gnt_valid, can_load, sel_ok, fifo_ok, fifo_idle;
  logic [PE_COUNT-1:0] credit_ok, exec_fire, elig, dec;
  function automatic int wrap(input int j);
    return (j >= PE_COUNT) ? j - PE_COUNT : j;
  endfunction
  assign sel_ok = {1'b0, pe_sel} < PE_LIM;
  assign can_load = !commit_out_valid || commit_out_ready;
  assign execute_out_data = {PE_COUNT{execute_in_data}};
  assign exec_fire = execute_out_valid & execute_out_ready;
  assign dec = commit_in_valid & commit_in_ready & commit_in_eop;
`ifdef VX_PE_DISPATCH_ORDERED_EN
  localparam int FA_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int FC_W = $clog2(ORDER_DEPTH + 1);
  logic [PE_SEL_BITS-1:0] fifo_mem [ORDER_DEPTH];
  logic [FA_W-1:0] wr_ptr, rd_ptr;
  logic [FC_W-1:0] fifo_cnt;
  logic fifo_push, fifo_pop, fifo_empty;
  assign fifo_empty = fifo_cnt == '0;
  assign fifo_push = |exec_fire;
  assign fifo_pop = |dec;
  assign fifo_ok = (fifo_cnt != FC_W'(ORDER_DEPTH)) || fifo_pop;
  assign fifo_idle = fifo_empty;
  always_comb begin
    elig = '0;
    for (int i = 0; i < PE_COUNT; i++)
      elig[i] = commit_in_valid[i] && !fifo_empty && fifo_mem[rd_ptr] == PE_SEL_BITS'(i);
  end
  always_ff @(posedge clk) if (fifo_push) fifo_mem[wr_ptr] <= pe_sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == FA_W'(ORDER_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= (rd_ptr == FA_W'(ORDER_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + FC_W'(fifo_push) - FC_W'(fifo_pop);
    end
  end
`else
  assign fifo_ok = 1'b1;
  assign fifo_idle = 1'b1;
  assign elig = commit_in_valid;
`endif
  always_comb begin
    credit_ok = '0;
    execute_out_valid = '0;
    execute_in_ready = 1'b0;
    for (int i = 0; i < PE_COUNT; i++) begin
      credit_ok[i] = pending[i] < CNT_W'(MAX_PENDING);
      if (sel_ok && pe_sel == PE_SEL_BITS'(i)) begin
        execute_out_valid[i] = execute_in_valid && credit_ok[i] && fifo_ok;
        execute_in_ready = execute_out_ready[i] && credit_ok[i] && fifo_ok;
      end
    end
  end
  // walk from the far end so the candidate nearest the pointer wins last
  always_comb begin
    gnt_valid = 1'b0;
    win = '0;
    for (int k = PE_COUNT - 1; k >= 0; k--)
      if (elig[wrap(int'(rr_ptr) + k)]) begin
        gnt_valid = 1'b1;
        win = PE_SEL_BITS'(wrap(int'(rr_ptr) + k));
      end
  end
  always_comb begin
    commit_in_ready = '0;
    commit_in_ready[win] = gnt_valid && can_load;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PE_COUNT; i++) pending[i] <= '0;
      rr_ptr <= '0;
      commit_out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < PE_COUNT; i++)
        if (exec_fire[i] && !dec[i]) pending[i] <= pending[i] + 1'b1;
        else if (dec[i] && !exec_fire[i] && pending[i] != '0) pending[i] <= pending[i] - 1'b1;
      if (gnt_valid && can_load) begin
        commit_out_valid <= 1'b1;
        commit_out_data <= commit_in_data[win];
        commit_out_eop <= commit_in_eop[win];
        rr_ptr <= PE_SEL_BITS'(wrap(int'(win) + 1));
      end else if (commit_out_ready) commit_out_valid <= 1'b0;
    end
  end
  always_comb begin
    pe_busy = '0;
    for (int i = 0; i < PE_COUNT; i++) pe_busy[i] = pending[i] != '0;
    idle = !commit_out_valid && !(|pe_busy) && fifo_idle;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(execute_in_valid && !sel_ok));
      assert (ORDER_DEPTH >= 1);
      for (int i = 0; i < PE_COUNT; i++) assert (!(dec[i] && pending[i] == '0));
    end
  end
endmodule
